aes_sbox_scheduler: RTL
=======================

# aes_sbox_scheduler

Time-shares a reduced bank of `LANES` AES S-box instances between two requesters. The data-path requester sends a full 128-bit SubBytes state; the key-expansion requester sends a 32-bit SubWord. Each requester uses its own valid/ready request and response channels. The block replaces the 16-S-box SubBytes stage in area-constrained AES-128 builds and sits between the round controller and the key-expansion unit.

## Interface
Parameters:
- `LANES`, default 4, is the number of S-box instances. Legal values are 4, 8 and 16, so that 16 is divisible by `LANES` and one SubWord fits in one pass.

Ports:
- `clk`  in  1  is the single clock. All state changes on its rising edge.
- `rst_n`  in  1  is the reset. It is asynchronous and active-low.
- `st_req_valid`  in  1  indicates a state request is pending.
- `st_req_ready`  out  1  indicates the state request is accepted this cycle.
- `st_req_data`  in  128  is the state. Byte k is `[127-8k -: 8]`.
- `st_rsp_valid`  out  1  indicates the substituted state is available.
- `st_rsp_ready`  in  1  indicates the consumer takes the state response.
- `st_rsp_data`  out  128  is the substituted state, in the same byte order as the request.
- `kw_req_valid`  in  1  indicates a key-word request is pending.
- `kw_req_ready`  out  1  indicates the key-word request is accepted this cycle.
- `kw_req_word`  in  32  is the key word. Byte k is `[31-8k -: 8]`.
- `kw_rsp_valid`  out  1  indicates SubWord(word) is available.
- `kw_rsp_ready`  in  1  indicates the consumer takes the key-word response.
- `kw_rsp_word`  out  32  is the substituted word.
- `busy`  out  1  is high whenever the state is not IDLE.

## Operation
- The FSM has five states: IDLE, ST_RUN, KW_RUN, ST_DONE and KW_DONE.
- Grants are made only in IDLE:
  - `grant_st = st_req_valid & (!kw_req_valid | last_grant==KW)`.
  - `grant_kw = kw_req_valid & (!st_req_valid | last_grant==ST)`.
  - `*_req_ready` equals the corresponding grant in IDLE and is 0 in every other state.
- On accept, the request operand is captured into an internal register. Later changes on the request inputs are ignored. `last_grant` is updated to the granted requester and `cnt` is cleared.
- ST_RUN:
  - Each cycle, lanes 0..`LANES`-1 take state bytes `cnt*LANES .. cnt*LANES+LANES-1`.
  - Results are written into the same byte positions of the response register, and `cnt` increments.
  - After `16/LANES` cycles the FSM moves to ST_DONE.
- KW_RUN:
  - Lanes 0..3 take word bytes 0..3. Lanes 4 and above are driven with 0x00 and their outputs are ignored.
  - The FSM moves to KW_DONE after one cycle.
- ST_DONE / KW_DONE:
  - `*_rsp_valid` is 1, and data is held stable until `*_rsp_ready`.
  - On the handshake the FSM returns to IDLE.
  - There is no accept in the same cycle; the next grant can occur one cycle later at the earliest.
- There is no preemption. A pending request waits until the FSM is back in IDLE.
- Reset values: state IDLE, `last_grant`=KW (so the first tie goes to ST), `cnt`=0, `busy`=0, both `*_rsp_valid`=0, and both response data registers all-zero.
- While `rst_n` is low, both `*_req_ready` are forced to 0.
- If reset asserts mid-operation, the operation is aborted immediately: no response is issued and all valids drop asynchronously.

## Timing
- State latency: `st_rsp_valid` rises `16/LANES` cycles after the accept edge. That is 4 cycles at `LANES`=4 and 1 cycle at `LANES`=16.
- Key-word latency: `kw_rsp_valid` rises 1 cycle after the accept edge.
- Best-case occupancy is latency + 1 (the response-handshake cycle in DONE) + 1 (the re-grant cycle in IDLE). For example, ST at `LANES`=4 repeats every 6 cycles.
- Simultaneous valids from both requesters alternate strictly: ST, KW, ST, …
- Response backpressure holds the block in DONE indefinitely. `busy` stays 1 and the other requester stalls.
- The S-box path is combinational within one cycle. Only the operand register, response register, `cnt` and the FSM are sequential.

## Structure
- Shared package `aes_pkg`:
  - `aes_state_t` (logic [127:0]) and `aes_word_t` (logic [31:0]).
  - Constant `AES_NUM_BYTES`=16.
  - Enum `sbox_sched_e` for the FSM states.
  - Enum `sbox_req_e` {ST, KW}.
- One sub-module, `aes_sbox_bank`, containing `LANES` instances of `AES_SBOX` on a flat `8*LANES` input and output bus.
- Lane-input selection from `cnt` and the requester stays in the scheduler.

## Test plan
- **State request, all-zero:** `LANES`=4, idle accept of state 0x00…00 → `st_rsp_valid` exactly 4 cycles after accept, data 0x6363…63, `busy`=1 throughout.
- **State request, FIPS-197 vector:** state 0x193de3bea0f4e22b9ac68d2ae9f84808 → 0xd42711aee0bf98f1b8b45de51e415230. Repeat with `LANES`=8 (2-cycle latency) and `LANES`=16 (1-cycle latency).
- **Key word:** `kw_req_word`=0xcf4f3c09 → `kw_rsp_word`=0x8a84eb01 one cycle after accept.
- **Tie and alternation:** both valid out of reset → ST granted first, then KW, then ST. Neither requester is starved over 8 back-to-back pairs. Operand changes after accept do not affect the result.
- **Backpressure:** hold `st_rsp_ready`=0 for 10 cycles with `kw_req_valid`=1 → `st_rsp_data` stable, `kw_req_ready` stays 0, KW is granted the cycle after the state handshake.
- **Reset mid-operation:** deassert `rst_n` during ST_RUN cycle 2 → all valids and readies go 0 at once and the response data resets to 0. After release, a new KW request completes normally with no stale ST response.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES types, constants and the forward S-box function.
//                Contents:
//                  aes_state_t / aes_word_t : 128-bit state, 32-bit key word
//                  AES_NUM_BYTES            : bytes per AES state
//                  sbox_sched_e             : scheduler FSM states
//                  sbox_req_e               : requester identity (ST, KW)
//                  sbox_fwd()               : combinational forward S-box
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    localparam int AES_NUM_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_RUN  = 3'd1,
        KW_RUN  = 3'd2,
        ST_DONE = 3'd3,
        KW_DONE = 3'd4
    } sbox_sched_e;

    typedef enum logic {
        ST = 1'b0,
        KW = 1'b1
    } sbox_req_e;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0 naturally), then the
    // AES affine transform. The loop accumulates a^2 * a^4 * ... * a^128.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] b;
        sq = a;
        b  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            b  = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/AES_SBOX.sv
`default_nettype none
// ============================================================================
//  Module      : AES_SBOX
//  Description : Single combinational AES forward S-box.
//                Ports: in_byte (8) -> out_byte (8)
//  Revision    : 1.0  initial release
// ============================================================================
module AES_SBOX
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_fwd(in_byte);

endmodule
`default_nettype wire

// File: rtl/aes_sbox_bank.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox_bank
//  Description : LANES parallel S-boxes on flat buses. Lane 0 occupies the
//                most-significant byte so the bus order matches AES byte order.
//                Ports: lane_in (8*LANES) -> lane_out (8*LANES)
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sbox_bank #(
    parameter int LANES = 4
) (
    input  logic [8*LANES-1:0] lane_in,
    output logic [8*LANES-1:0] lane_out
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        AES_SBOX u_sbox (
            .in_byte  (lane_in [8*LANES-1-8*l -: 8]),
            .out_byte (lane_out[8*LANES-1-8*l -: 8])
        );
    end

endmodule
`default_nettype wire

// File: rtl/aes_sbox_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox_scheduler
//  Description : Time-shares LANES S-boxes between a 128-bit state requester
//                (ST) and a 32-bit key-word requester (KW), with round-robin
//                arbitration on ties and valid/ready request/response channels.
//                Ports:
//                  clk, rst_n                         clock, async active-low reset
//                  st_req_valid/ready/data[127:0]     state request
//                  st_rsp_valid/ready/data[127:0]     substituted state
//                  kw_req_valid/ready/word[31:0]      key-word request
//                  kw_rsp_valid/ready/word[31:0]      SubWord result
//                  busy                               FSM not idle
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sbox_scheduler
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_req_data,
    output logic         st_rsp_valid,
    input  logic         st_rsp_ready,
    output logic [127:0] st_rsp_data,
    input  logic         kw_req_valid,
    output logic         kw_req_ready,
    input  logic [31:0]  kw_req_word,
    output logic         kw_rsp_valid,
    input  logic         kw_rsp_ready,
    output logic [31:0]  kw_rsp_word,
    output logic         busy
);

    localparam int PASSES = AES_NUM_BYTES / LANES;
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int LW     = 8 * LANES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASSES - 1);

    sbox_sched_e      state_q, state_d;
    sbox_req_e        last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    aes_state_t       op_q, op_d;
    aes_state_t       st_rsp_q, st_rsp_d;
    aes_word_t        kw_rsp_q, kw_rsp_d;
    logic             st_rsp_valid_q, st_rsp_valid_d;
    logic             kw_rsp_valid_q, kw_rsp_valid_d;
    logic             busy_q, busy_d;

    logic             grant_st, grant_kw;
    int               bit_off;
    aes_state_t       window, lane_out_ext, lane_mask;
    logic [LW-1:0]    lane_in, lane_out;

    // Round-robin tie break: the requester not served last wins.
    assign grant_st = st_req_valid & (~kw_req_valid | (last_grant_q == KW));
    assign grant_kw = kw_req_valid & (~st_req_valid | (last_grant_q == ST));

    assign st_req_ready = rst_n & (state_q == IDLE) & grant_st;
    assign kw_req_ready = rst_n & (state_q == IDLE) & grant_kw;

    // Lane window: bytes cnt*LANES .. cnt*LANES+LANES-1 of the operand.
    // A key word is stored in the top 32 bits with zeros below, so with cnt=0
    // lanes 0..3 see the word bytes and any higher lanes see 0x00.
    always_comb begin
        bit_off      = int'(cnt_q) * LW;
        window       = op_q << bit_off;
        lane_in      = window[127 -: LW];
        lane_out_ext = '0;
        lane_out_ext[127 -: LW] = lane_out;
        lane_out_ext = lane_out_ext >> bit_off;
        lane_mask    = '0;
        lane_mask[127 -: LW] = '1;
        lane_mask    = lane_mask >> bit_off;
    end

    aes_sbox_bank #(
        .LANES (LANES)
    ) u_bank (
        .lane_in  (lane_in),
        .lane_out (lane_out)
    );

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        st_rsp_d       = st_rsp_q;
        kw_rsp_d       = kw_rsp_q;
        st_rsp_valid_d = st_rsp_valid_q;
        kw_rsp_valid_d = kw_rsp_valid_q;

        unique case (state_q)
            IDLE: begin
                if (grant_st) begin
                    op_d         = st_req_data;
                    last_grant_d = ST;
                    cnt_d        = '0;
                    state_d      = ST_RUN;
                end else if (grant_kw) begin
                    op_d         = {kw_req_word, 96'h0};
                    last_grant_d = KW;
                    cnt_d        = '0;
                    state_d      = KW_RUN;
                end
            end
            ST_RUN: begin
                st_rsp_d = (st_rsp_q & ~lane_mask) | lane_out_ext;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    state_d        = ST_DONE;
                    st_rsp_valid_d = 1'b1;
                end
            end
            KW_RUN: begin
                kw_rsp_d       = lane_out[LW-1 -: 32];
                state_d        = KW_DONE;
                kw_rsp_valid_d = 1'b1;
            end
            ST_DONE: begin
                if (st_rsp_ready) begin
                    state_d        = IDLE;
                    st_rsp_valid_d = 1'b0;
                end
            end
            KW_DONE: begin
                if (kw_rsp_ready) begin
                    state_d        = IDLE;
                    kw_rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= KW;
            cnt_q          <= '0;
            op_q           <= '0;
            st_rsp_q       <= '0;
            kw_rsp_q       <= '0;
            st_rsp_valid_q <= 1'b0;
            kw_rsp_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            st_rsp_q       <= st_rsp_d;
            kw_rsp_q       <= kw_rsp_d;
            st_rsp_valid_q <= st_rsp_valid_d;
            kw_rsp_valid_q <= kw_rsp_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign st_rsp_valid = st_rsp_valid_q;
    assign st_rsp_data  = st_rsp_q;
    assign kw_rsp_valid = kw_rsp_valid_q;
    assign kw_rsp_word  = kw_rsp_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire
